// File: rtl/sfp_link_ctrl.sv
// SFP link bring-up controller: debounces module presence, qualifies PHY block
// lock, times out into PHY datapath resets, and tracks link drops and retries.
module sfp_link_ctrl #(
  parameter int DEBOUNCE_CYCLES     = 1024,
  parameter int LOCK_QUAL_CYCLES    = 4096,
  parameter int LOCK_TIMEOUT_CYCLES = 15625000,
  parameter int RESET_HOLD_CYCLES   = 64,
  parameter int BLINK_LOG2          = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sfp_npres,
  input  logic        sfp_los,
  input  logic        rx_block_lock,
  input  logic        rx_high_ber,
  output logic        sfp_tx_disable,
  output logic        phy_rst_req,
  output logic        link_up,
  output logic [1:0]  led,
  output logic [1:0]  state,
  output logic [15:0] drop_count,
  output logic [7:0]  retry_count
);

  typedef enum logic [1:0] {
    ST_ABSENT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_PHY_RST   = 2'd2,
    ST_UP        = 2'd3
  } state_e;

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int QUAL_W  = $clog2(LOCK_QUAL_CYCLES + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int HOLD_W  = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int BLINK_W = BLINK_LOG2;

  state_e              state_q, state_d;
  logic                pres_db_q, pres_db_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [QUAL_W-1:0]   qual_cnt_q, qual_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                tx_dis_q, tx_dis_d;
  logic                rst_req_q, rst_req_d;
  logic                link_up_q, link_up_d;
  logic [1:0]          led_q, led_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic [7:0]          retry_cnt_q, retry_cnt_d;

  logic qual_ok, qual_done, to_done, hold_done, acq_q, acq_d;

  assign qual_ok   = rx_block_lock & ~rx_high_ber;
  assign qual_done = qual_ok && (qual_cnt_q == QUAL_W'(LOCK_QUAL_CYCLES - 1));
  assign to_done   = ~sfp_los && (to_cnt_q == TO_W'(LOCK_TIMEOUT_CYCLES - 1));
  assign hold_done = (hold_cnt_q == HOLD_W'(RESET_HOLD_CYCLES - 1));
  assign acq_q     = (state_q == ST_WAIT_LOCK) || (state_q == ST_PHY_RST);
  assign acq_d     = (state_d == ST_WAIT_LOCK) || (state_d == ST_PHY_RST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ABSENT;
      pres_db_q   <= 1'b0;
      db_cnt_q    <= '0;
      qual_cnt_q  <= '0;
      to_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      tx_dis_q    <= 1'b1;
      rst_req_q   <= 1'b0;
      link_up_q   <= 1'b0;
      led_q       <= 2'b00;
      drop_cnt_q  <= 16'd0;
      retry_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      pres_db_q   <= pres_db_d;
      db_cnt_q    <= db_cnt_d;
      qual_cnt_q  <= qual_cnt_d;
      to_cnt_q    <= to_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      tx_dis_q    <= tx_dis_d;
      rst_req_q   <= rst_req_d;
      link_up_q   <= link_up_d;
      led_q       <= led_d;
      drop_cnt_q  <= drop_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  // The debounce count runs only while the pin disagrees with the accepted level.
  always_comb begin
    pres_db_d = pres_db_q;
    db_cnt_d  = '0;
    if (sfp_npres == pres_db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        pres_db_d = ~sfp_npres;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ABSENT:    if (pres_db_q) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (qual_done)    state_d = ST_UP;
        else if (to_done) state_d = ST_PHY_RST;
      end
      ST_PHY_RST:   if (hold_done) state_d = ST_WAIT_LOCK;
      ST_UP:        if (!qual_ok) state_d = ST_WAIT_LOCK;
      default:      state_d = ST_ABSENT;
    endcase
    if (!pres_db_q) state_d = ST_ABSENT;
  end

  // Per-state counters restart whenever their state is entered or left.
  always_comb begin
    qual_cnt_d  = '0;
    to_cnt_d    = '0;
    hold_cnt_d  = '0;
    drop_cnt_d  = drop_cnt_q;
    retry_cnt_d = retry_cnt_q;
    if (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK) begin
      if (qual_ok)  qual_cnt_d = qual_cnt_q + QUAL_W'(1);
      if (!sfp_los) to_cnt_d   = to_cnt_q + TO_W'(1);
    end
    if (state_q == ST_PHY_RST && state_d == ST_PHY_RST) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
    if (state_q != ST_PHY_RST && state_d == ST_PHY_RST && retry_cnt_q != 8'hFF) begin
      retry_cnt_d = retry_cnt_q + 8'd1;
    end
    if (state_q == ST_UP && state_d == ST_WAIT_LOCK && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_comb begin
    tx_dis_d    = (state_d == ST_ABSENT);
    rst_req_d   = (state_d == ST_PHY_RST);
    link_up_d   = (state_d == ST_UP);
    blink_cnt_d = '0;
    led_d       = {1'b0, link_up_d};
    if (acq_q && acq_d) begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      led_d[1]    = led_q[1] ^ (&blink_cnt_q);
    end
  end

  assign sfp_tx_disable = tx_dis_q;
  assign phy_rst_req    = rst_req_q;
  assign link_up        = link_up_q;
  assign led            = led_q;
  assign state          = state_q;
  assign drop_count     = drop_cnt_q;
  assign retry_count    = retry_cnt_q;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Directed bench for sfp_link_ctrl with short parameters (4/8/100/10/3).
module tb_sfp_link_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sfp_npres = 1'b1;
  logic        sfp_los = 1'b1;
  logic        rx_block_lock = 1'b0;
  logic        rx_high_ber = 1'b0;
  logic        sfp_tx_disable, phy_rst_req, link_up;
  logic [1:0]  led, state;
  logic [15:0] drop_count;
  logic [7:0]  retry_count;

  int checks = 0;
  int failures = 0;

  sfp_link_ctrl #(
    .DEBOUNCE_CYCLES(4), .LOCK_QUAL_CYCLES(8), .LOCK_TIMEOUT_CYCLES(100),
    .RESET_HOLD_CYCLES(10), .BLINK_LOG2(3)
  ) dut (
    .clk(clk), .rst(rst), .sfp_npres(sfp_npres), .sfp_los(sfp_los),
    .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
    .sfp_tx_disable(sfp_tx_disable), .phy_rst_req(phy_rst_req), .link_up(link_up),
    .led(led), .state(state), .drop_count(drop_count), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++;
    if ({state, sfp_tx_disable, phy_rst_req, link_up, led} !== {2'd0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL reset_outputs: got st=%0d txd=%b req=%b up=%b led=%b", state, sfp_tx_disable, phy_rst_req, link_up, led);
    end
    checks++;
    if ({drop_count, retry_count} !== 24'd0) begin
      failures++;
      $display("FAIL reset_counts: got drop=%0h retry=%0h want 0/0", drop_count, retry_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_debounce();
    step(3);
    sfp_npres = 1'b0;
    step(3);
    sfp_npres = 1'b1;
    step(4);
    checks++;
    if (state !== 2'd0 || sfp_tx_disable !== 1'b1) begin
      failures++;
      $display("FAIL glitch_ignored: got st=%0d txd=%b want 0/1", state, sfp_tx_disable);
    end
    sfp_npres = 1'b0;
    step(4);
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL debounce_early: got st=%0d want 0", state);
    end
    step(1);
    checks++;
    if (state !== 2'd1 || sfp_tx_disable !== 1'b0 || led !== 2'b00) begin
      failures++;
      $display("FAIL enter_wait: got st=%0d txd=%b led=%b want 1/0/00", state, sfp_tx_disable, led);
    end
  endtask

  task automatic test_qualify();
    rx_block_lock = 1'b1;
    step(7);
    checks++;
    if (state !== 2'd1 || led !== 2'b00) begin
      failures++;
      $display("FAIL qual_7: got st=%0d led=%b want 1/00", state, led);
    end
    rx_block_lock = 1'b0;
    step(1);
    checks++;
    if (state !== 2'd1 || led !== 2'b10) begin
      failures++;
      $display("FAIL qual_break_blink: got st=%0d led=%b want 1/10", state, led);
    end
    rx_block_lock = 1'b1;
    step(7);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL qual_early: got st=%0d want 1", state);
    end
    step(1);
    checks++;
    if (state !== 2'd3 || link_up !== 1'b1 || led !== 2'b01 || sfp_tx_disable !== 1'b0) begin
      failures++;
      $display("FAIL qual_up: got st=%0d up=%b led=%b txd=%b want 3/1/01/0", state, link_up, led, sfp_tx_disable);
    end
  endtask

  task automatic test_drop();
    rx_high_ber = 1'b1;
    step(1);
    rx_high_ber = 1'b0;
    checks++;
    if (state !== 2'd1 || drop_count !== 16'd1 || link_up !== 1'b0) begin
      failures++;
      $display("FAIL drop_once: got st=%0d drop=%0d up=%b want 1/1/0", state, drop_count, link_up);
    end
    step(8);
    checks++;
    if (state !== 2'd3 || drop_count !== 16'd1) begin
      failures++;
      $display("FAIL relock: got st=%0d drop=%0d want 3/1", state, drop_count);
    end
    force dut.drop_cnt_q = 16'hFFFF;
    step(1);
    release dut.drop_cnt_q;
    rx_high_ber = 1'b1;
    step(1);
    rx_high_ber = 1'b0;
    checks++;
    if (state !== 2'd1 || drop_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL drop_saturate: got st=%0d drop=%0h want 1/ffff", state, drop_count);
    end
  endtask

  task automatic test_timeout();
    logic saw_rst;
    logic req_ok;
    saw_rst = 1'b0;
    rx_block_lock = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (state == 2'd2 || phy_rst_req) saw_rst = 1'b1;
    end
    checks++;
    if (saw_rst !== 1'b0 || retry_count !== 8'd0) begin
      failures++;
      $display("FAIL los_blocks_timeout: got saw_rst=%b retry=%0d want 0/0", saw_rst, retry_count);
    end
    sfp_los = 1'b0;
    step(99);
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL timeout_early: got st=%0d want 1", state);
    end
    step(1);
    checks++;
    if (state !== 2'd2 || phy_rst_req !== 1'b1 || retry_count !== 8'd1) begin
      failures++;
      $display("FAIL timeout_rst: got st=%0d req=%b retry=%0d want 2/1/1", state, phy_rst_req, retry_count);
    end
    req_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (phy_rst_req !== 1'b1 || state !== 2'd2) req_ok = 1'b0;
    end
    checks++;
    if (req_ok !== 1'b1) begin
      failures++;
      $display("FAIL rst_pulse_short: got req_ok=%b want 1", req_ok);
    end
    step(1);
    checks++;
    if (state !== 2'd1 || phy_rst_req !== 1'b0 || retry_count !== 8'd1) begin
      failures++;
      $display("FAIL rst_pulse_end: got st=%0d req=%b retry=%0d want 1/0/1", state, phy_rst_req, retry_count);
    end
  endtask

  task automatic test_npres_in_phy_rst();
    step(100);
    checks++;
    if (state !== 2'd2 || retry_count !== 8'd2) begin
      failures++;
      $display("FAIL second_timeout: got st=%0d retry=%0d want 2/2", state, retry_count);
    end
    sfp_npres = 1'b1;
    step(4);
    checks++;
    if (state !== 2'd2 || phy_rst_req !== 1'b1) begin
      failures++;
      $display("FAIL npres_debounce: got st=%0d req=%b want 2/1", state, phy_rst_req);
    end
    step(1);
    checks++;
    if (state !== 2'd0 || phy_rst_req !== 1'b0 || sfp_tx_disable !== 1'b1 || led !== 2'b00) begin
      failures++;
      $display("FAIL npres_abort: got st=%0d req=%b txd=%b led=%b want 0/0/1/00", state, phy_rst_req, sfp_tx_disable, led);
    end
  endtask

  task automatic test_reset_in_up();
    sfp_npres = 1'b0;
    step(5);
    rx_block_lock = 1'b1;
    step(8);
    checks++;
    if (state !== 2'd3 || drop_count !== 16'hFFFF || retry_count !== 8'd2) begin
      failures++;
      $display("FAIL retained_counts: got st=%0d drop=%0h retry=%0d want 3/ffff/2", state, drop_count, retry_count);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if ({state, sfp_tx_disable, phy_rst_req, link_up, led, drop_count, retry_count} !==
        {2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_in_up: got st=%0d txd=%b req=%b up=%b led=%b drop=%0h retry=%0d",
               state, sfp_tx_disable, phy_rst_req, link_up, led, drop_count, retry_count);
    end
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_qualify();
    test_drop();
    test_timeout();
    test_npres_in_phy_rst();
    test_reset_in_up();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfp_link_ctrl.md
SFP_LINK_CTRL -- requirements
Module: sfp_link_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1024: consecutive cycles a changed sfp_npres level must persist before it is accepted.
REQ-002 Parameter LOCK_QUAL_CYCLES, default 4096: consecutive qualified-lock cycles required to declare link up.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 15625000: cycles allowed in WAIT_LOCK (with los low) before a PHY reset is requested.
REQ-004 Parameter RESET_HOLD_CYCLES, default 64: width of the phy_rst_req pulse, in cycles.
REQ-005 Parameter BLINK_LOG2, default 23: led[1] toggles every 2^BLINK_LOG2 cycles while in WAIT_LOCK.
REQ-006 clk  input  1  single clock; the 156.25 MHz PHY TX clock.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 sfp_npres  input  1  module not present, already synchronous to clk.
REQ-009 sfp_los  input  1  receive loss of signal, already synchronous to clk.
REQ-010 rx_block_lock  input  1  PHY block lock, already synchronous to clk.
REQ-011 rx_high_ber  input  1  PHY high bit error rate, already synchronous to clk.
REQ-012 sfp_tx_disable  output  1  drives the SFP TX disable pin.
REQ-013 phy_rst_req  output  1  PHY datapath reset request.
REQ-014 link_up  output  1  link qualified.
REQ-015 led  output  2  led[0]=link_up; led[1]=blink while acquiring.
REQ-016 state  output  2  current state: ABSENT=0, WAIT_LOCK=1, PHY_RST=2, UP=3.
REQ-017 drop_count  output  16  number of UP->WAIT_LOCK transitions; saturates at 0xFFFF.
REQ-018 retry_count  output  8  number of entries into PHY_RST; saturates at 0xFF.

Function
REQ-019 Debounce: internal pres_db SHALL take the value ~sfp_npres only after sfp_npres has differed from ~pres_db for DEBOUNCE_CYCLES consecutive cycles; any single matching cycle clears the debounce counter.
REQ-020 All outputs SHALL be registered, Moore-decoded from state, and SHALL change on the clock edge that enters the new state.
REQ-021 ABSENT: sfp_tx_disable=1, link_up=0; -> WAIT_LOCK on the cycle after pres_db becomes 1.
REQ-022 WAIT_LOCK: sfp_tx_disable=0; the timeout counter is cleared on entry and increments each cycle sfp_los=0; any cycle with sfp_los=1 clears it.
REQ-023 The qualification counter increments while rx_block_lock=1 and rx_high_ber=0 and clears on any other cycle; on reaching LOCK_QUAL_CYCLES the block goes -> UP.
REQ-024 Timeout counter reaching LOCK_TIMEOUT_CYCLES -> PHY_RST; if qualification and timeout complete in the same cycle, UP wins.
REQ-025 PHY_RST: phy_rst_req=1 for exactly RESET_HOLD_CYCLES cycles, then -> WAIT_LOCK; retry_count increments once on entry.
REQ-026 UP: link_up=1; rx_block_lock=0 or rx_high_ber=1 for a single cycle -> WAIT_LOCK, with drop_count incremented once.
REQ-027 pres_db=0 in any state SHALL force -> ABSENT on the next edge, with priority over all other transitions; phy_rst_req deasserts immediately.
REQ-028 led[1] SHALL toggle every 2^BLINK_LOG2 cycles in WAIT_LOCK and PHY_RST, and SHALL be 0 in ABSENT and UP.
REQ-029 Counters SHALL saturate and never wrap; count values are retained across ABSENT.

Reset
REQ-030 rst SHALL force the following values on the next edge, regardless of the current state: state=ABSENT, pres_db=0, sfp_tx_disable=1, phy_rst_req=0, link_up=0, led=0, drop_count=0, retry_count=0, and all internal counters cleared.
REQ-031 rst asserted during PHY_RST SHALL terminate the pulse: phy_rst_req=0 on the next edge.

Verification (DEBOUNCE=4, LOCK_QUAL=8, LOCK_TIMEOUT=100, RESET_HOLD=10, BLINK_LOG2=3)
REQ-032 Drive npres=0 continuously -> pres_db set after 4 cycles; tx_disable=0 and state=1 on the following edge; a 3-cycle npres=0 glitch produces no state change.
REQ-033 In WAIT_LOCK, hold lock=1 for 7 cycles, drop it for 1 cycle, then hold lock=1 for 8 cycles -> state=3 only after the final 8-cycle run completes.
REQ-034 Hold lock=0, los=0 -> state=2 at cycle 100; phy_rst_req high for exactly 10 cycles; retry_count=1; then state=1; holding los=1 instead -> no PHY_RST ever occurs.
REQ-035 In UP, pulse high_ber for 1 cycle -> state=1 and drop_count=1; preload drop_count to 0xFFFF and repeat -> count stays at 0xFFFF.
REQ-036 Assert npres for 4 cycles during PHY_RST -> state=0, phy_rst_req=0, tx_disable=1; assert rst mid-UP -> all outputs at their reset values on the next edge.
